audio_channel_scheduler: RTL and testbench

- Sits between the I2S receiver and the I2S transmitter in the codec loopback path, in the bit-clock domain.
- Captures each stereo frame when the receiver signals completion.
- Time-shares one processing engine (the denoise core) between the left and right channels, using a valid/ready request and a done pulse.
- Enforces a per-channel cycle budget with passthrough fallback, applies bypass and mute, and presents stable held samples to the transmitter.

---
 rtl/audio_pkg.sv | 16 +
 rtl/audio_channel_scheduler_if.sv | 23 ++
 rtl/sat_counter.sv | 20 ++
 rtl/audio_channel_scheduler.sv | 174 +++++++++++++++++
 tb/tb_audio_channel_scheduler.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio channel scheduler slice.
package audio_pkg;

   localparam int unsigned DW_DEFAULT = 16;
   localparam int unsigned CNT_W      = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_L,
      S_WAIT_L,
      S_REQ_R,
      S_WAIT_R,
      S_COMMIT
   } state_e;

endpackage

// File: rtl/audio_channel_scheduler_if.sv
// Valid/ready request plus done-pulse link between the scheduler and the denoise engine.
interface audio_channel_scheduler_if
   import audio_pkg::*;
#(
   parameter int unsigned DW = DW_DEFAULT
);
   logic          eng_req;
   logic          eng_ch;
   logic [DW-1:0] eng_din;
   logic          eng_ready;
   logic          eng_done;
   logic [DW-1:0] eng_dout;

   modport master (
      output eng_req, eng_ch, eng_din,
      input  eng_ready, eng_done, eng_dout
   );

   modport slave (
      input  eng_req, eng_ch, eng_din,
      output eng_ready, eng_done, eng_dout
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter; a clear in the same cycle as an increment wins.
module sat_counter
   import audio_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/audio_channel_scheduler.sv
// Captures stereo frames, time-shares the denoise engine between L and R with a
// per-channel cycle budget, and commits held samples to the I2S transmitter.
module audio_channel_scheduler
   import audio_pkg::*;
#(
   parameter int unsigned DW      = DW_DEFAULT,
   parameter int unsigned TIMEOUT = 24
) (
   input  logic                      bclk,
   input  logic                      rst,
   input  logic                      rx_done,
   input  logic [DW-1:0]             rx_l_data,
   input  logic [DW-1:0]             rx_r_data,
   input  logic                      bypass,
   input  logic                      mute,
   audio_channel_scheduler_if.master eng,
   output logic [DW-1:0]             tx_l_data,
   output logic [DW-1:0]             tx_r_data,
   output logic                      frame_ok,
   output logic [CNT_W-1:0]          timeout_cnt,
   output logic [CNT_W-1:0]          overrun_cnt,
   input  logic                      err_clr
);

   localparam int unsigned   TW       = 8;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_e        state, state_d;
   logic [DW-1:0] cap_l, cap_r, res_l, res_r;
   logic [DW-1:0] cap_l_d, cap_r_d, res_l_d, res_r_d;
   logic [TW-1:0] timer, timer_d;
   logic          req_q, req_d, ch_q, ch_d;
   logic [DW-1:0] din_q, din_d;
   logic [DW-1:0] tx_l_d, tx_r_d;
   logic          frame_ok_d;
   logic          tmo_inc_c, ovr_inc_c;
   logic          chan_r_c, expire_c, finish_c;
   logic [DW-1:0] cap_x_c, res_x_c;

   assign eng.eng_req = req_q;
   assign eng.eng_ch  = ch_q;
   assign eng.eng_din = din_q;

   // Any frame arriving while a frame is in flight is dropped.
   assign ovr_inc_c = rx_done && (state != S_IDLE);

   // Next-state and next-output logic; L and R share the request/wait handling.
   always_comb begin
      state_d    = state;
      cap_l_d    = cap_l;
      cap_r_d    = cap_r;
      res_l_d    = res_l;
      res_r_d    = res_r;
      timer_d    = timer;
      req_d      = 1'b0;
      ch_d       = ch_q;
      din_d      = din_q;
      tx_l_d     = tx_l_data;
      tx_r_d     = tx_r_data;
      frame_ok_d = 1'b0;
      tmo_inc_c  = 1'b0;
      finish_c   = 1'b0;
      chan_r_c   = (state == S_REQ_R) || (state == S_WAIT_R);
      cap_x_c    = chan_r_c ? cap_r : cap_l;
      res_x_c    = cap_x_c;
      expire_c   = (timer == TMO_LAST);

      case (state)
         S_IDLE: begin
            if (rx_done) begin
               cap_l_d = rx_l_data;
               cap_r_d = rx_r_data;
               timer_d = '0;
               if (bypass) begin
                  res_l_d = rx_l_data;
                  res_r_d = rx_r_data;
                  state_d = S_COMMIT;
               end else begin
                  state_d = S_REQ_L;
               end
            end
         end
         S_REQ_L, S_REQ_R: begin
            timer_d = timer + TW'(1);
            ch_d    = chan_r_c;
            din_d   = cap_x_c;
            if (expire_c) begin
               finish_c  = 1'b1;
               tmo_inc_c = 1'b1;
            end else if (req_q && eng.eng_ready) begin
               state_d = chan_r_c ? S_WAIT_R : S_WAIT_L;
            end else begin
               req_d = 1'b1;
            end
         end
         S_WAIT_L, S_WAIT_R: begin
            timer_d = timer + TW'(1);
            if (eng.eng_done) begin
               finish_c = 1'b1;
               res_x_c  = eng.eng_dout;
            end else if (expire_c) begin
               finish_c  = 1'b1;
               tmo_inc_c = 1'b1;
            end
         end
         S_COMMIT: begin
            tx_l_d     = mute ? '0 : res_l;
            tx_r_d     = mute ? '0 : res_r;
            frame_ok_d = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Channel finished (done or passthrough): store result and advance.
      if (finish_c) begin
         timer_d = '0;
         if (chan_r_c) begin
            res_r_d = res_x_c;
            state_d = S_COMMIT;
         end else begin
            res_l_d = res_x_c;
            state_d = S_REQ_R;
         end
      end
   end

   always_ff @(posedge bclk) begin
      if (rst) begin
         state     <= S_IDLE;
         cap_l     <= '0;
         cap_r     <= '0;
         res_l     <= '0;
         res_r     <= '0;
         timer     <= '0;
         req_q     <= 1'b0;
         ch_q      <= 1'b0;
         din_q     <= '0;
         tx_l_data <= '0;
         tx_r_data <= '0;
         frame_ok  <= 1'b0;
      end else begin
         state     <= state_d;
         cap_l     <= cap_l_d;
         cap_r     <= cap_r_d;
         res_l     <= res_l_d;
         res_r     <= res_r_d;
         timer     <= timer_d;
         req_q     <= req_d;
         ch_q      <= ch_d;
         din_q     <= din_d;
         tx_l_data <= tx_l_d;
         tx_r_data <= tx_r_d;
         frame_ok  <= frame_ok_d;
      end
   end

   sat_counter u_timeout_cnt (
      .clk (bclk),
      .rst (rst),
      .inc (tmo_inc_c),
      .clr (err_clr),
      .cnt (timeout_cnt)
   );

   sat_counter u_overrun_cnt (
      .clk (bclk),
      .rst (rst),
      .inc (ovr_inc_c),
      .clr (err_clr),
      .cnt (overrun_cnt)
   );

endmodule

// File: tb/tb_audio_channel_scheduler.sv
// Directed bench for audio_channel_scheduler with a behavioural denoise engine
// that returns din ^ 16'hFFFF a programmable number of cycles after acceptance.
module tb_audio_channel_scheduler;
   import audio_pkg::*;

   logic        bclk;
   logic        rst;
   logic        rx_done;
   logic [15:0] rx_l_data, rx_r_data;
   logic        bypass, mute, err_clr;
   logic [15:0] tx_l_data, tx_r_data;
   logic        frame_ok;
   logic [7:0]  timeout_cnt, overrun_cnt;

   audio_channel_scheduler_if #(.DW(16)) eng_bus ();

   audio_channel_scheduler #(.DW(16), .TIMEOUT(24)) dut (
      .bclk        (bclk),
      .rst         (rst),
      .rx_done     (rx_done),
      .rx_l_data   (rx_l_data),
      .rx_r_data   (rx_r_data),
      .bypass      (bypass),
      .mute        (mute),
      .eng         (eng_bus),
      .tx_l_data   (tx_l_data),
      .tx_r_data   (tx_r_data),
      .frame_ok    (frame_ok),
      .timeout_cnt (timeout_cnt),
      .overrun_cnt (overrun_cnt),
      .err_clr     (err_clr)
   );

   initial bclk = 1'b0;
   always #5 bclk = ~bclk;

   int n_checks = 0;
   int n_fail   = 0;

   // Engine model knobs (written only by the stimulus process).
   int          eng_k      = 3;
   bit          drop_left  = 1'b0;
   int          stray_req  = 0;
   // Engine model state (written only by the engine process).
   int          pend       = 0;
   int          stray_seen = 0;
   logic [15:0] pend_dout;

   // Engine: handshake seen in cycle a -> done pulse in cycle a+eng_k.
   always @(negedge bclk) begin
      eng_bus.eng_done = 1'b0;
      if (rst) pend = 0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            eng_bus.eng_done = 1'b1;
            eng_bus.eng_dout = pend_dout;
         end
      end
      if (stray_req != stray_seen) begin
         stray_seen       = stray_req;
         eng_bus.eng_done = 1'b1;
         eng_bus.eng_dout = 16'h5555;
      end
      if (eng_bus.eng_req && eng_bus.eng_ready && !(drop_left && (eng_bus.eng_ch == 1'b0))) begin
         pend      = eng_k;
         pend_dout = eng_bus.eng_din ^ 16'hFFFF;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge bclk);
      #1;
   endtask

   // Drive one rx_done pulse; returns in cycle t+1.
   task automatic send(input logic [15:0] l, input logic [15:0] r, input logic byp);
      rx_l_data = l;
      rx_r_data = r;
      bypass    = byp;
      rx_done   = 1'b1;
      tick();
      rx_done   = 1'b0;
   endtask

   task automatic wait_frame(input int max_cyc, output int n);
      n = 0;
      while (frame_ok !== 1'b1 && n < max_cyc) begin
         tick();
         n++;
      end
      check("frame_seen", 32'(frame_ok), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   int n;

   initial begin
      rst = 1'b1; rx_done = 1'b0; rx_l_data = '0; rx_r_data = '0;
      bypass = 1'b0; mute = 1'b0; err_clr = 1'b0;
      eng_bus.eng_ready = 1'b1;
      repeat (3) tick();
      check("rst_eng_req", 32'(eng_bus.eng_req), 32'd0);
      check("rst_eng_din", 32'(eng_bus.eng_din), 32'd0);
      check("rst_tx_l", 32'(tx_l_data), 32'd0);
      check("rst_frame_ok", 32'(frame_ok), 32'd0);
      check("rst_counters", {16'd0, timeout_cnt, overrun_cnt}, 32'd0);
      rst = 1'b0;
      tick();

      // Bypass: output at t+2, engine untouched.
      send(16'h1234, 16'hABCD, 1'b1);
      check("byp_t1_frame_ok", 32'(frame_ok), 32'd0);
      check("byp_t1_eng_req", 32'(eng_bus.eng_req), 32'd0);
      tick();
      check("byp_t2_frame_ok", 32'(frame_ok), 32'd1);
      check("byp_tx", {tx_l_data, tx_r_data}, 32'h1234ABCD);
      tick();
      check("byp_t3_frame_ok", 32'(frame_ok), 32'd0);
      check("byp_t3_eng_req", 32'(eng_bus.eng_req), 32'd0);
      check("byp_hold_tx", {tx_l_data, tx_r_data}, 32'h1234ABCD);

      // Engine path, k=3: output at t+12.
      bypass = 1'b0;
      send(16'h1234, 16'hABCD, 1'b0);
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) tick();
         case (c)
            2: check("eng_req_l", {15'd0, eng_bus.eng_req, eng_bus.eng_ch, eng_bus.eng_din}, {15'd0, 1'b1, 1'b0, 16'h1234});
            4: check("eng_wait_l", {15'd0, eng_bus.eng_req, eng_bus.eng_ch, eng_bus.eng_din}, {15'd0, 1'b0, 1'b0, 16'h1234});
            7: check("eng_req_r", {15'd0, eng_bus.eng_req, eng_bus.eng_ch, eng_bus.eng_din}, {15'd0, 1'b1, 1'b1, 16'hABCD});
            11: check("eng_t11_frame_ok", 32'(frame_ok), 32'd0);
            12: begin
               check("eng_t12_frame_ok", 32'(frame_ok), 32'd1);
               check("eng_tx", {tx_l_data, tx_r_data}, 32'hEDCB5432);
            end
            default: ;
         endcase
      end
      tick();

      // Backpressure: ready low for five request cycles.
      eng_bus.eng_ready = 1'b0;
      send(16'h1111, 16'h2222, 1'b0);
      for (int c = 2; c <= 6; c++) begin
         tick();
         check($sformatf("bp_hold_c%0d", c), {15'd0, eng_bus.eng_req, eng_bus.eng_ch, eng_bus.eng_din}, {15'd0, 1'b1, 1'b0, 16'h1111});
      end
      tick();
      eng_bus.eng_ready = 1'b1;
      check("bp_req_c7", 32'(eng_bus.eng_req), 32'd1);
      tick();
      check("bp_req_drop", 32'(eng_bus.eng_req), 32'd0);
      wait_frame(20, n);
      check("bp_latency", 32'(n), 32'd9);
      check("bp_tx", {tx_l_data, tx_r_data}, 32'hEEEEDDDD);
      tick();

      // Timeout on left: passthrough left, right processed.
      drop_left = 1'b1;
      send(16'h0F0F, 16'hF00F, 1'b0);
      repeat (23) tick();
      check("tmo_before_expiry", 32'(timeout_cnt), 32'd0);
      tick();
      check("tmo_after_expiry", 32'(timeout_cnt), 32'd1);
      drop_left = 1'b0;
      wait_frame(10, n);
      check("tmo_latency", 32'(n), 32'd6);
      check("tmo_tx", {tx_l_data, tx_r_data}, 32'h0F0F0FF0);
      stray_req++;
      repeat (3) tick();
      check("stray_frame_ok", 32'(frame_ok), 32'd0);
      check("stray_tx", {tx_l_data, tx_r_data}, 32'h0F0F0FF0);
      check("stray_tmo_cnt", 32'(timeout_cnt), 32'd1);

      // Done arriving in the expiry cycle wins over the timeout.
      eng_k = 22;
      send(16'h00FF, 16'hFF00, 1'b0);
      wait_frame(60, n);
      check("edge_latency", 32'(n), 32'd49);
      check("edge_tx", {tx_l_data, tx_r_data}, 32'hFF0000FF);
      check("edge_tmo_cnt", 32'(timeout_cnt), 32'd1);
      eng_k = 3;
      tick();

      // Overrun while in WAIT_L; first frame still commits.
      send(16'h0A0A, 16'h0B0B, 1'b0);
      repeat (3) tick();
      rx_l_data = 16'h7777; rx_r_data = 16'h8888; rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      check("ovr_cnt_1", 32'(overrun_cnt), 32'd1);
      wait_frame(20, n);
      check("ovr_latency", 32'(n), 32'd7);
      check("ovr_tx", {tx_l_data, tx_r_data}, 32'hF5F5F4F4);
      tick();

      // Mute at COMMIT, plus a dropped rx_done in COMMIT.
      send(16'h1357, 16'h2468, 1'b1);
      mute = 1'b1; bypass = 1'b0; rx_done = 1'b1;
      tick();
      mute = 1'b0; rx_done = 1'b0;
      check("mute_frame_ok", 32'(frame_ok), 32'd1);
      check("mute_tx", {tx_l_data, tx_r_data}, 32'd0);
      check("ovr_cnt_commit", 32'(overrun_cnt), 32'd2);

      // Saturation of overrun_cnt.
      eng_bus.eng_ready = 1'b0;
      rx_done = 1'b1;
      repeat (300) tick();
      rx_done = 1'b0;
      check("ovr_saturated", 32'(overrun_cnt), 32'd255);
      eng_bus.eng_ready = 1'b1;
      repeat (60) tick();

      // Clear wins over a coincident increment.
      send(16'h0001, 16'h0002, 1'b0);
      rx_done = 1'b1; err_clr = 1'b1;
      tick();
      rx_done = 1'b0; err_clr = 1'b0;
      check("clr_overrun", 32'(overrun_cnt), 32'd0);
      check("clr_timeout", 32'(timeout_cnt), 32'd0);
      wait_frame(20, n);
      check("clr_latency", 32'(n), 32'd10);
      check("clr_tx", {tx_l_data, tx_r_data}, 32'hFFFEFFFD);
      tick();

      // Reset asserted in WAIT_R.
      send(16'h4444, 16'h5555, 1'b0);
      repeat (7) tick();
      check("rst_pre_eng_ch", 32'(eng_bus.eng_ch), 32'd1);
      rst = 1'b1;
      tick();
      check("midrst_eng_req", 32'(eng_bus.eng_req), 32'd0);
      check("midrst_tx", {tx_l_data, tx_r_data}, 32'd0);
      check("midrst_frame_ok", 32'(frame_ok), 32'd0);
      rst = 1'b0;
      repeat (5) tick();
      check("postrst_frame_ok", 32'(frame_ok), 32'd0);
      check("postrst_eng_req", 32'(eng_bus.eng_req), 32'd0);
      check("postrst_tx", {tx_l_data, tx_r_data}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
